// File: rtl/mem2p_be_pipe.sv
// Two-port RAM: one byte-enabled write port, one read port with 1- or 2-cycle latency.
// Define MEM2P_CLEAR_EN to zero the whole array after every reset (requests ignored while busy_o).
module mem2p_be_pipe #(
  parameter  int W  = 32,
  parameter  int D  = 128,
  parameter  int BW = 8,
  parameter  int RL = 1,
  localparam int DW = $clog2(D),
  localparam int NL = W / BW
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          we1_i,
  input  logic [NL-1:0] be1_i,
  input  logic [DW-1:0] addr1_i,
  input  logic [W-1:0]  din1_i,
  input  logic          re2_i,
  input  logic [DW-1:0] addr2_i,
  output logic [W-1:0]  dout2_o,
  output logic          dout2_valid_o,
  output logic          busy_o,
  output logic [DW-1:0] array_size_o
);

  logic          busy;
  logic          wr_in_range;
  logic          rd_in_range;
  logic          port1_wr;
  logic          rd_acc;
  logic          fwd_hit;

  logic          wr_en;
  logic [DW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [NL-1:0] wr_be;

  logic [W-1:0]  mem_q [D];
  logic [W-1:0]  rd_word_q;

  logic          s0_valid_q;
  logic          s0_zero_q;
  logic [NL-1:0] s0_fwd_be_q;
  logic [W-1:0]  s0_fwd_data_q;
  logic [W-1:0]  s0_word;

  assign array_size_o = DW'(DW);

  // A power-of-two depth leaves no address outside the array.
  generate
    if (D == (1 << DW)) begin : g_pow2
      assign wr_in_range = 1'b1;
      assign rd_in_range = 1'b1;
    end else begin : g_npow2
      localparam logic [DW:0] D_EXT = D[DW:0];
      assign wr_in_range = ({1'b0, addr1_i} < D_EXT);
      assign rd_in_range = ({1'b0, addr2_i} < D_EXT);
    end
  endgenerate

  assign port1_wr = we1_i & ~busy & wr_in_range;
  assign rd_acc   = re2_i & ~busy;
  assign fwd_hit  = port1_wr & (addr1_i == addr2_i);

`ifdef MEM2P_CLEAR_EN
  typedef enum logic {CLEAR, READY} state_t;

  state_t        state_q;
  logic [DW-1:0] sweep_q;
  logic          busy_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= CLEAR;
      sweep_q <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          sweep_q <= sweep_q + 1'b1;
          if (sweep_q == DW'(D - 1)) begin
            state_q <= READY;
            busy_q  <= 1'b0;
          end
        end
        READY: begin
          busy_q <= 1'b0;
        end
        default: begin
          state_q <= CLEAR;
          sweep_q <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign busy = busy_q;

  // The sweep owns the write port for its whole duration.
  always_comb begin
    wr_en   = port1_wr;
    wr_addr = addr1_i;
    wr_data = din1_i;
    wr_be   = be1_i;
    if (state_q == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = sweep_q;
      wr_data = '0;
      wr_be   = '1;
    end
  end
`else
  assign busy    = 1'b0;
  assign wr_en   = port1_wr;
  assign wr_addr = addr1_i;
  assign wr_data = din1_i;
  assign wr_be   = be1_i;
`endif

  assign busy_o = busy;

  // Array has no reset so it maps onto block RAM; read data is registered.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int l = 0; l < NL; l++) begin
        if (wr_be[l]) begin
          mem_q[wr_addr][l*BW +: BW] <= wr_data[l*BW +: BW];
        end
      end
    end
    if (rd_acc) begin
      rd_word_q <= mem_q[addr2_i];
    end
  end

  // Side-band state captured with each accepted read: forwarding lanes and out-of-range flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s0_valid_q    <= 1'b0;
      s0_zero_q     <= 1'b1;
      s0_fwd_be_q   <= '0;
      s0_fwd_data_q <= '0;
    end else begin
      s0_valid_q <= rd_acc;
      if (rd_acc) begin
        s0_zero_q     <= ~rd_in_range;
        s0_fwd_be_q   <= fwd_hit ? be1_i : '0;
        s0_fwd_data_q <= din1_i;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NL; gi++) begin : g_lane
      assign s0_word[gi*BW +: BW] = s0_zero_q       ? '0 :
                                    s0_fwd_be_q[gi] ? s0_fwd_data_q[gi*BW +: BW] :
                                                      rd_word_q[gi*BW +: BW];
    end
  endgenerate

  generate
    if (RL == 1) begin : g_rl1
      assign dout2_o       = s0_word;
      assign dout2_valid_o = s0_valid_q;
    end else begin : g_rl2
      logic [W-1:0] dout_q;
      logic         valid_q;

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= s0_valid_q;
          if (s0_valid_q) begin
            dout_q <= s0_word;
          end
        end
      end

      assign dout2_o       = dout_q;
      assign dout2_valid_o = valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_mem2p_be_pipe.sv
// Bench for mem2p_be_pipe: an RL=1 instance (D=12, has out-of-range addresses) and an RL=2 instance (D=16)
// share one stimulus stream and are checked against a lane-level memory model with a result queue.
module tb_mem2p_be_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        we1;
  logic [3:0]  be1;
  logic [3:0]  addr1;
  logic [31:0] din1;
  logic        re2;
  logic [3:0]  addr2;

  logic [31:0] dout_a, dout_b;
  logic        vld_a, vld_b, busy_a, busy_b;
  logic [3:0]  size_a, size_b;

  mem2p_be_pipe #(.W(32), .D(12), .BW(8), .RL(1)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .we1_i(we1), .be1_i(be1), .addr1_i(addr1), .din1_i(din1),
    .re2_i(re2), .addr2_i(addr2), .dout2_o(dout_a), .dout2_valid_o(vld_a), .busy_o(busy_a),
    .array_size_o(size_a)
  );

  mem2p_be_pipe #(.W(32), .D(16), .BW(8), .RL(2)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .we1_i(we1), .be1_i(be1), .addr1_i(addr1), .din1_i(din1),
    .re2_i(re2), .addr2_i(addr2), .dout2_o(dout_b), .dout2_valid_o(vld_b), .busy_o(busy_b),
    .array_size_o(size_b)
  );

`ifdef MEM2P_CLEAR_EN
  localparam int CLR_A = 12;
  localparam int CLR_B = 16;
`else
  localparam int CLR_A = 0;
  localparam int CLR_B = 0;
`endif

  typedef struct {
    int          inst;
    int          due;
    logic [31:0] data;
  } res_t;

  int          nchk  = 0;
  int          npass = 0;
  int          nfail = 0;
  int          cyc   = 0;
  logic [31:0] mdl [2][16];
  int          dep  [2] = '{12, 16};
  int          rlat [2] = '{1, 2};
  res_t        pend [$];
  logic [31:0] held [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int l = 0; l < 4; l++) if (be[l]) r[8*l +: 8] = nw[8*l +: 8];
    return r;
  endfunction

  task automatic check_out();
    for (int k = 0; k < 2; k++) begin
      logic ev;
      ev = 1'b0;
      for (int j = pend.size() - 1; j >= 0; j--) begin
        if (pend[j].inst == k && pend[j].due == cyc) begin
          ev      = 1'b1;
          held[k] = pend[j].data;
          pend.delete(j);
        end
      end
      if (k == 0) begin
        chk("valid_a", 32'(vld_a), 32'(ev));
        chk("dout_a", dout_a, held[0]);
      end else begin
        chk("valid_b", 32'(vld_b), 32'(ev));
        chk("dout_b", dout_b, held[1]);
      end
    end
  endtask

  // One clock of stimulus, starting and ending on a falling edge.
  task automatic step(input logic we, input logic [3:0] be, input logic [3:0] a1, input logic [31:0] d1,
                      input logic re, input logic [3:0] a2);
    logic [31:0] r;
    we1 = we; be1 = be; addr1 = a1; din1 = d1; re2 = re; addr2 = a2;
    for (int k = 0; k < 2; k++) begin
      if (re) begin
        if (int'(a2) >= dep[k]) r = '0;
        else begin
          r = mdl[k][a2];
          if (we && a1 == a2) r = merge(r, d1, be);
        end
        pend.push_back('{k, cyc + rlat[k], r});
      end
    end
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++)
      if (we && int'(a1) < dep[k]) mdl[k][a1] = merge(mdl[k][a1], d1, be);
    @(negedge clk);
    check_out();
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
    step(1'b1, be, a, d, 1'b0, 4'd0);
  endtask

  task automatic rd(input logic [3:0] a);
    step(1'b0, 4'h0, 4'd0, 32'd0, 1'b1, a);
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 4'd0, 32'd0, 1'b0, 4'd0);
  endtask

  // Counts busy cycles after reset release while firing requests that must be ignored.
  task automatic clear_wait();
    int n1, n2;
    n1 = 0; n2 = 0;
    for (int i = 0; i < 64; i++) begin
      if (busy_a) n1++;
      if (busy_b) n2++;
      chk("clr_valid_a", 32'(vld_a), 32'd0);
      chk("clr_valid_b", 32'(vld_b), 32'd0);
      if (!busy_a && !busy_b) break;
      we1 = (i >= 1 && i < 8); be1 = 4'hF; addr1 = 4'd0; din1 = 32'hFFFF_FFFF;
      re2 = (i < 8); addr2 = 4'(i);
      @(posedge clk);
      @(negedge clk);
    end
    we1 = 1'b0; re2 = 1'b0; be1 = 4'h0; addr1 = 4'd0; addr2 = 4'd0; din1 = 32'd0;
    chk("busy_cycles_a", 32'(n1), 32'(CLR_A));
    chk("busy_cycles_b", 32'(n2), 32'(CLR_B));
  endtask

  task automatic zero_model();
`ifdef MEM2P_CLEAR_EN
    for (int k = 0; k < 2; k++) for (int a = 0; a < 16; a++) mdl[k][a] = 32'd0;
`endif
  endtask

  initial begin
    logic [3:0] ra1;
    rst_n = 1'b0; we1 = 1'b0; be1 = 4'h0; addr1 = 4'd0; din1 = 32'd0; re2 = 1'b0; addr2 = 4'd0;
    held[0] = 32'd0; held[1] = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_dout_a", dout_a, 32'd0);
    chk("rst_valid_a", 32'(vld_a), 32'd0);
    chk("rst_dout_b", dout_b, 32'd0);
    chk("rst_valid_b", 32'(vld_b), 32'd0);
    chk("rst_busy_b", 32'(busy_b), (CLR_B > 0) ? 32'd1 : 32'd0);
    chk("size_a", 32'(size_a), 32'd4);
    chk("size_b", 32'(size_b), 32'd4);

    rst_n = 1'b1;
    clear_wait();
`ifdef MEM2P_CLEAR_EN
    zero_model();
`else
    for (int a = 0; a < 16; a++) wr(4'(a), 4'hF, $urandom);
`endif
    for (int a = 0; a < 16; a++) rd(4'(a));
    idle(); idle();

    wr(4'd3, 4'hF, 32'hAABB_CCDD);
    wr(4'd3, 4'h2, 32'h1122_3344);
    rd(4'd3);
    chk("rmw_a", dout_a, 32'hAABB_33DD);
    chk("rmw_valid_a", 32'(vld_a), 32'd1);
    idle();
    chk("rmw_b", dout_b, 32'hAABB_33DD);

    wr(4'd5, 4'hF, 32'd0);
    step(1'b1, 4'hC, 4'd5, 32'hDEAD_BEEF, 1'b1, 4'd5);
    chk("fwd_a", dout_a, 32'hDEAD_0000);
    idle();
    chk("fwd_b", dout_b, 32'hDEAD_0000);

    wr(4'd7, 4'hF, 32'd1);
    rd(4'd7);
    wr(4'd7, 4'hF, 32'd2);
    chk("late_wr_b", dout_b, 32'd1);
    rd(4'd7);
    chk("reread_a", dout_a, 32'd2);
    idle();
    chk("reread_b", dout_b, 32'd2);

    for (int a = 0; a < 4; a++) wr(4'(a), 4'hF, 32'(a));
    for (int a = 0; a < 4; a++) rd(4'(a));
    idle(); idle();
    chk("hold_b", dout_b, 32'd3);
    chk("hold_valid_b", 32'(vld_b), 32'd0);

    rd(4'd13);
    wr(4'd14, 4'hF, 32'h1234_5678);
    rd(4'd14);
    wr(4'd6, 4'h0, 32'hFFFF_FFFF);
    rd(4'd6);
    idle();

    rd(4'd7);
    re2 = 1'b1; addr2 = 4'd5;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_dout_a", dout_a, 32'd0);
    chk("async_valid_a", 32'(vld_a), 32'd0);
    chk("async_dout_b", dout_b, 32'd0);
    chk("async_valid_b", 32'(vld_b), 32'd0);
    pend.delete();
    held[0] = 32'd0; held[1] = 32'd0;
    re2 = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_wait();
    zero_model();
    for (int a = 0; a < 16; a++) rd(4'(a));
    idle(); idle();

    for (int i = 0; i < 300; i++) begin
      ra1 = 4'($urandom_range(0, 15));
      step(1'($urandom), 4'($urandom), ra1, $urandom, 1'($urandom),
           ($urandom_range(0, 1) == 1) ? ra1 : 4'($urandom_range(0, 15)));
    end
    idle(); idle(); idle();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/mem2p_be_pipe.md
MEM2P_BE_PIPE -- requirements
Module: mem2p_be_pipe

Interface
REQ-001 Parameter W, default 32, data width in bits; SHALL be a multiple of BW.
REQ-002 Parameter D, default 128, depth in words; SHALL be at least 2; DW = clog2(D) is derived, not settable.
REQ-003 Parameter BW, default 8, lane width in bits; NL = W/BW lanes.
REQ-004 Parameter RL, default 1, read latency in cycles; legal values 1 or 2.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 we1  in  1  write request, port 1.
REQ-008 be1  in  NL  lane write enables, port 1.
REQ-009 addr1  in  DW  write address.
REQ-010 din1  in  W  write data.
REQ-011 re2  in  1  read request, port 2.
REQ-012 addr2  in  DW  read address.
REQ-013 dout2  out  W  read data.
REQ-014 dout2_valid  out  1  one-cycle pulse marking dout2 as the result of a read request.
REQ-015 busy  out  1  high while requests are being ignored (clear sweep).
REQ-016 array_size  out  DW  constant DW.

Function
REQ-017 Write: at a rising edge with we1=1, busy=0 and addr1<D, each lane i with be1[i]=1 SHALL take din1 lane i; lanes with be1[i]=0 SHALL be unchanged.
REQ-018 A write with addr1>=D SHALL be dropped; a write with be1=0 SHALL change nothing.
REQ-019 Read: a request (re2=1, busy=0) accepted at edge N SHALL drive dout2 and pulse dout2_valid=1 for exactly one cycle after edge N+RL-1; back-to-back reads SHALL give one result per cycle, in order.
REQ-020 A read with addr2>=D SHALL return all-zero data with dout2_valid=1.
REQ-021 Read-during-write to the same address at the same edge is write-first per lane: enabled lanes return din1, disabled lanes return the stored value.
REQ-022 With RL=2, a write landing at the edge between read acceptance and output SHALL NOT alter the read result; the result reflects memory state at acceptance, including REQ-021 forwarding.
REQ-023 dout2 SHALL hold its last value when no result is due; it SHALL NOT go X or zero between reads.
REQ-024 Requests SHALL be ignored while busy=1, with no write and no dout2_valid pulse.
REQ-025 A read accepted before busy rises SHALL still complete.

Reset
REQ-026 While rst_n=0: dout2=0, dout2_valid=0, read pipeline flushed (no pending results).
REQ-027 rst_n SHALL NOT directly reset the memory array.
REQ-028 Reset asserted mid-operation SHALL discard in-flight reads; no dout2_valid pulse SHALL follow deassertion for them.
REQ-029 Outputs SHALL change on rst_n falling, without waiting for clk.

Configuration
REQ-030 The macro MEM2P_CLEAR_EN controls the zero-clear sweep.
REQ-031 Defined: FSM states CLEAR and READY; reset enters CLEAR with a sweep address of 0 and busy=1.
REQ-032 In CLEAR, each edge SHALL write all-zero data to the sweep address and increment it; after writing D-1 the FSM SHALL enter READY and busy SHALL fall.
REQ-033 The sweep SHALL take exactly D cycles; reset during CLEAR SHALL restart it at address 0.
REQ-034 Not defined: no FSM, busy tied 0, memory contents after reset undefined; all other behaviour unchanged.

Verification (W=32, D=16, BW=8)
REQ-035 CLEAR_EN defined, release reset -> busy=1 for exactly 16 cycles; then reads of addresses 0..15 all return 0x00000000.
REQ-036 RL=1, write 0xAABBCCDD to addr 3 with be1=0xF, then be1=0x2 with din1=0x11223344, then read addr 3 -> dout2=0xAABB33DD, valid one cycle after acceptance.
REQ-037 RL=2, addr 5 holds 0x0; same-edge write 0xDEADBEEF with be1=0xC and read of addr 5 -> dout2=0xDEAD0000 two cycles later.
REQ-038 RL=2, read addr 7 (holds 0x1) accepted, write 0x2 to addr 7 on the next edge -> result 0x1; an immediate reread returns 0x2.
REQ-039 Four back-to-back reads of addrs 0..3 holding 0,1,2,3 -> four consecutive valid pulses with data 0,1,2,3, then dout2 holds 3.
REQ-040 rst_n low for one cycle with two reads in flight (RL=2) -> dout2=0 immediately and no valid pulse afterwards; with CLEAR_EN defined, the sweep restarts from address 0.
